// File: rtl/fir_frame_sequencer.sv
// Frame sequencer for the folded FIR: streams FRAME_LEN reads from the sample ROM,
// writes FRAME_LEN results LAT cycles later, with start/busy/done, abort and frame count.
module fir_frame_sequencer #(
    parameter int ADDR_W    = 8,
    parameter int FRAME_LEN = 256,
    parameter int LAT       = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [7:0]        frame_cnt,
    output logic              in_nce,
    output logic [ADDR_W-1:0] in_addr,
    output logic              filt_rstn,
    output logic              out_nce,
    output logic              out_nwrt,
    output logic [ADDR_W-1:0] out_addr
);
    localparam int CW = ADDR_W + 2;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0]     FL_C   = CW'(FRAME_LEN);
    localparam logic [CW-1:0]     LAT_C  = CW'(LAT);
    localparam logic [CW-1:0]     WEND_C = CW'(LAT + FRAME_LEN);
    localparam logic [CW-1:0]     LAST_C = CW'(LAT + FRAME_LEN - 1);
    localparam logic [ADDR_W-1:0] LAT_A  = ADDR_W'(LAT);

    logic [1:0]        state;
    logic [CW-1:0]     cyc;
    logic [CW-1:0]     cyc_nx;
    logic              go;
    logic              rd_nx;
    logic              wr_nx;
    logic [ADDR_W-1:0] wr_addr_nx;

    // Outputs are registered, so they are computed from the cycle count the FSM
    // is about to enter; this lands read 0 on the first RUN cycle.
    always_comb begin
        go     = 1'b0;
        cyc_nx = '0;
        case (state)
            S_IDLE: go = start && !abort;
            S_RUN: begin
                go     = !abort && (cyc != LAST_C);
                cyc_nx = cyc + 1'b1;
            end
            default: go = 1'b0;
        endcase
        rd_nx      = go && (cyc_nx < FL_C);
        wr_nx      = go && (cyc_nx >= LAT_C) && (cyc_nx < WEND_C);
        wr_addr_nx = cyc_nx[ADDR_W-1:0] - LAT_A;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cyc       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            frame_cnt <= 8'd0;
            in_nce    <= 1'b1;
            in_addr   <= '0;
            filt_rstn <= 1'b0;
            out_nce   <= 1'b1;
            out_nwrt  <= 1'b1;
            out_addr  <= '0;
        end else begin
            done      <= 1'b0;
            busy      <= go;
            filt_rstn <= go;
            in_nce    <= !rd_nx;
            out_nce   <= !wr_nx;
            out_nwrt  <= !wr_nx;
            if (rd_nx) in_addr  <= cyc_nx[ADDR_W-1:0];
            if (wr_nx) out_addr <= wr_addr_nx;
            case (state)
                S_IDLE: begin
                    cyc <= '0;
                    if (go) state <= S_RUN;
                end
                S_RUN: begin
                    cyc <= cyc_nx;
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (cyc == LAST_C) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        frame_cnt <= frame_cnt + 8'd1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fir_frame_sequencer.sv
// Directed bench for fir_frame_sequencer: three instances cover 8/3 (basic, busy-start,
// abort, reset), 4/6 (read/write gap) and the 256/6 default (257 back-to-back frames).
module tb_fir_frame_sequencer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic start_c = 1'b0, abort_c = 1'b0;
    logic busy_a, done_a, in_nce_a, filt_rstn_a, out_nce_a, out_nwrt_a;
    logic busy_b, done_b, in_nce_b, filt_rstn_b, out_nce_b, out_nwrt_b;
    logic busy_c, done_c, in_nce_c, filt_rstn_c, out_nce_c, out_nwrt_c;
    logic [7:0] frame_cnt_a, in_addr_a, out_addr_a;
    logic [7:0] frame_cnt_b, in_addr_b, out_addr_b;
    logic [7:0] frame_cnt_c, in_addr_c, out_addr_c;

    fir_frame_sequencer #(.ADDR_W(8), .FRAME_LEN(8), .LAT(3)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .frame_cnt(frame_cnt_a),
        .in_nce(in_nce_a), .in_addr(in_addr_a), .filt_rstn(filt_rstn_a),
        .out_nce(out_nce_a), .out_nwrt(out_nwrt_a), .out_addr(out_addr_a));

    fir_frame_sequencer #(.ADDR_W(8), .FRAME_LEN(4), .LAT(6)) u_b (
        .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .frame_cnt(frame_cnt_b),
        .in_nce(in_nce_b), .in_addr(in_addr_b), .filt_rstn(filt_rstn_b),
        .out_nce(out_nce_b), .out_nwrt(out_nwrt_b), .out_addr(out_addr_b));

    fir_frame_sequencer #(.ADDR_W(8), .FRAME_LEN(256), .LAT(6)) u_c (
        .clk(clk), .reset(reset), .start(start_c), .abort(abort_c),
        .busy(busy_c), .done(done_c), .frame_cnt(frame_cnt_c),
        .in_nce(in_nce_c), .in_addr(in_addr_c), .filt_rstn(filt_rstn_c),
        .out_nce(out_nce_c), .out_nwrt(out_nwrt_c), .out_addr(out_addr_c));

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {busy, done, in_nce, filt_rstn, out_nce, out_nwrt, in_addr, out_addr}
    function automatic logic [21:0] obs(input int w);
        case (w)
            0: return {busy_a, done_a, in_nce_a, filt_rstn_a, out_nce_a, out_nwrt_a, in_addr_a, out_addr_a};
            1: return {busy_b, done_b, in_nce_b, filt_rstn_b, out_nce_b, out_nwrt_b, in_addr_b, out_addr_b};
            default: return {busy_c, done_c, in_nce_c, filt_rstn_c, out_nce_c, out_nwrt_c, in_addr_c, out_addr_c};
        endcase
    endfunction

    function automatic logic [7:0] fcnt(input int w);
        case (w)
            0: return frame_cnt_a;
            1: return frame_cnt_b;
            default: return frame_cnt_c;
        endcase
    endfunction

    // k = cycles after the edge that sampled start (k=1 is the first RUN cycle)
    task automatic step_chk(input int w, input int fl, input int lat, input int k, input string tag);
        int c;
        bit rd, wr, dn, bz;
        logic [21:0] o;
        c  = k - 1;
        rd = (k >= 1) && (c < fl);
        wr = (k >= 1) && (c >= lat) && (c < lat + fl);
        dn = (k == lat + fl + 1);
        bz = (k >= 1) && (k <= lat + fl);
        o  = obs(w);
        chk($sformatf("%s ctl k=%0d", tag, k), {26'd0, o[21:16]}, {26'd0, bz, dn, !rd, bz, !wr, !wr});
        if (rd) chk($sformatf("%s in_addr k=%0d", tag, k), {24'd0, o[15:8]}, c);
        if (wr) chk($sformatf("%s out_addr k=%0d", tag, k), {24'd0, o[7:0]}, c - lat);
    endtask

    task automatic reset_chk(input int w, input string tag);
        chk($sformatf("%s rst ctl", tag), {26'd0, obs(w)[21:16]}, 32'b001011);
        chk($sformatf("%s rst addr", tag), {16'd0, obs(w)[15:0]}, 32'd0);
        chk($sformatf("%s rst frame_cnt", tag), {24'd0, fcnt(w)}, 32'd0);
    endtask

    int w, rd_n, wr_n, bad_n, dn_n;

    initial begin
        repeat (3) tick();
        reset_chk(0, "A");
        reset_chk(1, "B");
        reset_chk(2, "C");
        reset = 1'b0;
        tick();

        // basic frame with a start inside the frame and one in the done cycle
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step_chk(0, 8, 3, k, "basic");
            start_a = (k == 4 || k == 12);
            tick();
        end
        step_chk(0, 8, 3, 13, "basic");
        chk("basic frame_cnt", {24'd0, frame_cnt_a}, 32'd1);
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step_chk(0, 8, 3, k, "frame2");
            tick();
        end
        chk("frame2 frame_cnt", {24'd0, frame_cnt_a}, 32'd2);

        // read/write gap when LAT >= FRAME_LEN
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            step_chk(1, 4, 6, k, "gap");
            tick();
        end
        chk("gap frame_cnt", {24'd0, frame_cnt_b}, 32'd1);

        // abort mid-frame
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step_chk(0, 8, 3, k, "abort");
            abort_a = (k == 5);
            tick();
        end
        abort_a = 1'b0;
        chk("abort ctl", {26'd0, obs(0)[21:16]}, 32'b001011);
        abort_a = 1'b1;
        start_a = 1'b1;
        tick();
        abort_a = 1'b0;
        start_a = 1'b0;
        chk("abort+start idle", {26'd0, obs(0)[21:16]}, 32'b001011);
        dn_n = 0;
        for (int i = 0; i < 15; i++) begin
            if (done_a || busy_a) dn_n++;
            tick();
        end
        chk("abort no done", dn_n, 32'd0);
        chk("abort frame_cnt", {24'd0, frame_cnt_a}, 32'd2);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            step_chk(0, 8, 3, k, "restart");
            tick();
        end
        chk("restart frame_cnt", {24'd0, frame_cnt_a}, 32'd3);

        // reset during the write phase
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (5) tick();
        chk("midrst writing", {31'd0, out_nce_a}, 32'd0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        reset_chk(0, "midrst");
        repeat (3) tick();
        chk("midrst quiet", {26'd0, obs(0)[21:16]}, 32'b001011);

        // 257 back-to-back frames at default size
        rd_n = 0;
        wr_n = 0;
        bad_n = 0;
        start_c = 1'b1;
        for (int f = 0; f < 257; f++) begin
            w = 0;
            do begin
                tick();
                w++;
                if (!out_nwrt_c && out_nce_c) bad_n++;
                if (f == 0) begin
                    if (!in_nce_c) rd_n++;
                    if (!out_nce_c) wr_n++;
                    if (w == 256) chk("C last read", {23'd0, in_nce_c, in_addr_c}, 32'h0ff);
                    if (w == 257) chk("C read hold", {23'd0, in_nce_c, in_addr_c}, 32'h1ff);
                    if (w == 262) chk("C last write", {23'd0, out_nce_c, out_addr_c}, 32'h0ff);
                end
            end while (!done_c && w < 300);
            chk($sformatf("C spacing f=%0d", f), w, (f == 0) ? 263 : 264);
            if (!done_c) break;
            if (f == 255) chk("C frame_cnt wrap", {24'd0, frame_cnt_c}, 32'd0);
            if (f == 256) start_c = 1'b0;
        end
        chk("C reads", rd_n, 32'd256);
        chk("C writes", wr_n, 32'd256);
        chk("C nwrt without nce", bad_n, 32'd0);
        tick();
        tick();
        chk("C frame_cnt", {24'd0, frame_cnt_c}, 32'd1);
        chk("C idle", {26'd0, obs(2)[21:16]}, 32'b001011);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fir_frame_sequencer.md
Name: fir_frame_sequencer

Overview:
- Single-clock controller that sequences one frame through the folded FIR datapath.
- Reads FRAME_LEN samples from the input sample ROM, holds the filter in reset until the frame starts, and writes FRAME_LEN results into the output RAM after the filter latency.
- Replaces ad-hoc NCE/counter glue with a start/busy/done handshake, abort, and a completed-frame count.
- Sits between the system controller and the two memory macros plus the folded filter.

Parameters:
- ADDR_W, 8, address width of both memories (256-word macros).
- FRAME_LEN, 256, samples per frame; legal range 1..2^ADDR_W.
- LAT, 6, cycles from an input read address to the matching output write address; legal range 1..255.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  frame request; sampled only in IDLE.
- abort  input  1  synchronous cancel of the current frame.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse on frame completion.
- frame_cnt  output  8  count of completed frames (not aborted ones); wraps 255->0.
- in_nce  output  1  input memory chip enable, active-low.
- in_addr  output  ADDR_W  input memory address; macro RA = in_addr[ADDR_W-1:2], CA = in_addr[1:0].
- filt_rstn  output  1  folded filter reset, active-low.
- out_nce  output  1  output memory chip enable, active-low.
- out_nwrt  output  1  output memory write enable, active-low.
- out_addr  output  ADDR_W  output memory address.

Behaviour:
- Reset values (outputs registered):
  - busy=0, done=0, frame_cnt=0.
  - in_nce=1, in_addr=0, filt_rstn=0.
  - out_nce=1, out_nwrt=1, out_addr=0.
  - state=IDLE.
- FSM state IDLE:
  - All enables inactive; filt_rstn=0.
  - start=1 -> RUN next cycle, with internal cycle counter cyc=0.
- FSM state RUN:
  - busy=1, filt_rstn=1.
  - cyc increments each cycle; cyc width is ADDR_W+2.
  - in_nce=0 and in_addr=cyc while cyc < FRAME_LEN; otherwise in_nce=1 and in_addr holds its last value.
  - out_nce=0, out_nwrt=0 and out_addr=cyc-LAT while LAT <= cyc < LAT+FRAME_LEN; otherwise out_nce=1 and out_nwrt=1.
  - At cyc = LAT+FRAME_LEN-1 (last write) -> DONE.
- FSM state DONE (exactly one cycle):
  - done=1, busy=0, all enables inactive, filt_rstn=0.
  - frame_cnt increments.
  - Always -> IDLE; start is ignored in this cycle.
- Timing, with start sampled at edge t0:
  - Read k is presented at cycle t0+1+k.
  - Write k is presented at cycle t0+1+LAT+k.
  - done is high at cycle t0+1+LAT+FRAME_LEN.
- Read and write phases overlap when LAT < FRAME_LEN. When LAT >= FRAME_LEN there is a gap in which both nce are 1 and busy stays 1.
- start is ignored while busy=1 or done=1. No queuing.
- abort=1 in RUN:
  - Next cycle is IDLE: in_nce=1, out_nce=1, out_nwrt=1, filt_rstn=0, busy=0.
  - No done pulse; frame_cnt is unchanged.
  - abort in IDLE or DONE has no effect.
- abort and start both high in IDLE: abort wins and the FSM stays in IDLE.
- reset has priority over everything and may assert mid-frame. Outputs reach their reset values the next cycle, and no memory access is issued afterwards.
- out_nwrt is never 0 while out_nce is 1.
- At most FRAME_LEN writes are issued per frame. Addresses never exceed FRAME_LEN-1.

Test Plan:
- Basic frame (FRAME_LEN=8, LAT=3): reset, 1-cycle start at cycle 5 -> in_addr 0..7 with in_nce=0 on cycles 6..13; out_addr 0..7 with out_nce=out_nwrt=0 on cycles 9..16; done=1 only on cycle 17; frame_cnt=1.
- Gap case (FRAME_LEN=4, LAT=6): start -> reads on cycles +1..+4, both nce=1 on +5..+6, writes on +7..+10, done on +11, busy=1 throughout +1..+10.
- Start while busy (8/3): second start pulse 4 cycles after the first -> ignored, identical trace to the basic case; a start in the done cycle is also ignored; a start the cycle after done launches frame 2, with frame_cnt reaching 2.
- Abort (8/3): abort at cycle +5 -> next cycle all nce=1, filt_rstn=0, busy=0, no done, frame_cnt unchanged; a new start gives reads from address 0.
- Reset mid-frame: reset high during the write phase -> next cycle all outputs at reset values and frame_cnt=0.
- Defaults (256/6) with 257 back-to-back frames: in_addr wraps 255 with no overflow; frame_cnt wraps to 1; per-frame done spacing is 1+6+256+1 cycles.
